// File: rtl/rgb444_pack.sv
// rgb444_pack: packs 8-bit RGB pixels into 12-bit RGB444 frame-buffer words.
// Frames PIXELS pixels after an armed vsync edge. It produces a write strobe
// and a linear address for each packed word, and flags short frames.
// Optional macro RGB444_ROUND_EN selects rounding instead of truncation.
// Handshake: the output is a write-only strobe. When we=1, dout and addr are
// valid for exactly that cycle. There is no backpressure.
module rgb444_pack #(
    parameter int ADDR_W = 15,
    parameter int PIXELS = 19200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              de,
    input  logic [7:0]        r,
    input  logic [7:0]        g,
    input  logic [7:0]        b,
    output logic [11:0]       dout,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_vsync_d;
    logic [ADDR_W-1:0] r_count;
    logic [11:0]       r_dout;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_vs_edge;
    logic              w_accept;
    logic              w_last;
    logic              w_err;
    logic              w_count_clr;
    logic [11:0]       w_packed;

    // Reduce one 8-bit channel to a 4-bit nibble.
    function automatic logic [3:0] to_nib(input logic [7:0] x);
`ifdef RGB444_ROUND_EN
        logic [8:0] t;
        // The result stays below 256, so bits [7:4] hold the shifted value.
        t = {1'b0, x} - {5'b0, x[7:4]} + 9'd8;
        return t[7:4];
`else
        return x[7:4];
`endif
    endfunction

    assign w_vs_edge = vsync & ~r_vsync_d;
    assign w_packed  = {to_nib(r), to_nib(g), to_nib(b)};

    // Next state and per-cycle decisions. A vsync edge always beats de.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_err       = 1'b0;
        w_count_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_edge && capture_en) begin
                    w_next      = ST_CAPTURE;
                    w_count_clr = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (w_vs_edge) begin
                    w_err       = 1'b1;
                    w_count_clr = 1'b1;
                    w_next      = capture_en ? ST_CAPTURE : ST_IDLE;
                end else if (de) begin
                    w_accept = 1'b1;
                    if (r_count == LAST_IDX) begin
                        // Detect the terminal count before incrementing, so
                        // PIXELS == 2^ADDR_W never wraps.
                        w_last = 1'b1;
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_vs_edge) begin
                    w_count_clr = 1'b1;
                    w_next      = capture_en ? ST_CAPTURE : ST_IDLE;
                end
            end
            default: begin
                w_next      = ST_IDLE;
                w_count_clr = 1'b1;
            end
        endcase
    end

    // State, vsync history and pixel counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_vsync_d <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_next;
            r_vsync_d <= vsync;
            if (w_count_clr)
                r_count <= '0;
            else if (w_accept && !w_last)
                r_count <= r_count + ADDR_W'(1);
        end
    end

    // Registered outputs. dout and addr hold their values between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_we   <= w_accept;
            r_busy <= (w_next == ST_CAPTURE);
            r_done <= w_last;
            r_err  <= w_err;
            if (w_accept) begin
                r_dout <= w_packed;
                r_addr <= r_count;
            end
        end
    end

    assign dout       = r_dout;
    assign we         = r_we;
    assign addr       = r_addr;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule
